motor_update_scheduler: RTL and testbench
=========================================

Name: motor_update_scheduler

Overview:
Sits between the eight DShot speed decoders and the BL-Ctrl register/I2C side. Per-motor functions:
- Captures each new decoded speed.
- Enforces an arming sequence and a signal-loss failsafe.
- Round-robin arbitrates pending updates onto one valid/ready update port.
- Holds the committed 64-bit speed vector that the BL-Ctrl handler and status LED consume.

Parameters:
TIMEOUT_CYCLES, 320000, clk cycles without a frame before failsafe (20 ms at 16 MHz); 20-bit counter.
ARM_FRAMES, 16, consecutive zero-speed frames required to arm a motor; 1..255.
MAX_STEP, 4, maximum speed increase per committed update (used only with SLEW_LIMIT_EN).

Ports:
clk  input  1  system clock (16 MHz).
rst  input  1  asynchronous, active-high reset.
speed_valid  input  8  one-cycle strobe per motor on a new decoded frame; bit 0 = motor 1.
speedFlat  input  64  decoder speeds; motor 1 at [63:56] … motor 8 at [7:0]; sampled only on strobe.
upd_valid  output  1  update offered.
upd_motor  output  3  motor index, 0 = motor 1.
upd_speed  output  8  speed to commit.
upd_ready  input  1  consumer accepts; handshake = upd_valid & upd_ready.
targetSpeedFlat  output  64  committed speeds, same packing as speedFlat.
armed  output  8  per-motor armed status.
timeout_flags  output  8  per-motor signal-loss flag.

Behaviour:
Reset (async, takes effect immediately mid-operation):
- upd_valid=0, upd_motor=0, upd_speed=0, targetSpeedFlat=0, armed=0, timeout_flags=8'hFF.
- All pending bits clear; RR pointer = 0; timers = 0; arm counters = 0.

Capture (per motor m, on speed_valid[m]):
- Raw speed s = speedFlat slice for m.
- If armed[m]: cap[m] <= s.
- If not armed[m]:
  - s==0: arm_cnt increments, saturating at ARM_FRAMES. When it reaches ARM_FRAMES, armed[m] sets on the next cycle.
  - s!=0: arm_cnt <= 0.
  - In both cases cap[m] <= 0.
- Also on the strobe: pending[m] <= 1, timer[m] <= TIMEOUT_CYCLES, timeout_flags[m] <= 0.

Watchdog:
- Timer decrements each cycle while nonzero.
- The transition to 0 (no strobe that cycle) sets timeout_flags[m], clears armed[m] and arm_cnt, sets cap[m] <= 0 and pending[m] <= 1.
- At 0 the timer stays at 0 with no further action until the next strobe.
- Strobe and expiry in the same cycle: the strobe wins.

Arbiter states:
- IDLE, upd_valid=0:
  - If any pending bit is set, pick the first set bit searching from ptr upward, wrapping 7→0.
  - Load upd_motor and upd_speed from cap; clear that pending bit; enter OFFER.
  - upd_valid is registered. A strobe at cycle t gives the earliest upd_valid at t+2.
- OFFER, upd_valid=1:
  - upd_motor and upd_speed are held stable until the handshake; no re-arbitration.
  - On handshake: targetSpeedFlat slice <= upd_speed (visible the next cycle); ptr <= upd_motor+1 mod 8; return to IDLE.
  - Back-to-back grants are not required. One idle cycle between offers is allowed.
- A strobe for the offered motor during OFFER re-sets pending. The offer is unchanged; the new value is sent in a later grant (latest value wins).
- Repeated strobes on a pending motor overwrite cap; only one update results.
- upd_ready with upd_valid=0 is ignored.

Optional Feature:
SLEW_LIMIT_EN
- Defined:
  - At grant, if cap > committed + MAX_STEP, upd_speed = committed + MAX_STEP, and pending stays set so the motor ramps on later grants.
  - Compare in 9 bits; the result never exceeds cap or 255.
  - Decreases and timeout zeros pass through unlimited.
- Undefined: upd_speed = cap; no limiter logic is instantiated.

Test Plan:
1. Reset, then motor 1 sends 16 zero frames followed by speed 100 → armed[0]=1 after the 16th frame; the final update is motor=0, speed=100; targetSpeedFlat[63:56]=100; timeout_flags[0]=0.
2. Unarmed motor 3 sends speed 50 → upd_speed=0 for motor=2; arm count restarts; armed[2] stays 0.
3. Motors 2, 5 and 8 strobe in the same cycle, upd_ready=1, ptr=0 → grants in order 1, 4, 7 (indices), then ptr=0.
4. Armed motor 1 at 100 stops sending → exactly TIMEOUT_CYCLES cycles after the last strobe: timeout_flags[0]=1, armed[0]=0, update motor=0 speed=0, slice goes to 0.
5. upd_ready held low for 10 cycles during OFFER while the same motor strobes 80 then 90 → the offered value is stable; after acceptance, a second update offers 90.
6. SLEW_LIMIT_EN with MAX_STEP=4: armed motor jumps from 0 to 10 → committed sequence 4, 8, 10. Then a drop to 2 → commits 2 directly.

Source files
------------

// File: rtl/motor_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : motor_update_scheduler
// Purpose  : Collects decoded speeds from eight DShot decoders, applies a
//            per-motor arming sequence and a signal-loss watchdog, and
//            round-robin arbitrates pending updates onto one valid/ready
//            update port. Holds the committed 64-bit speed vector.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk             system clock (16 MHz)
//   rst             asynchronous active-high reset
//   speed_valid     [7:0]  per-motor new-frame strobe, bit 0 = motor 1
//   speedFlat       [63:0] decoded speeds, motor 1 at [63:56]
//   upd_valid       update offered
//   upd_motor       [2:0]  offered motor index (0 = motor 1)
//   upd_speed       [7:0]  offered speed
//   upd_ready       consumer accepts the offered update
//   targetSpeedFlat [63:0] committed speeds, same packing as speedFlat
//   armed           [7:0]  per-motor armed status
//   timeout_flags   [7:0]  per-motor signal-loss flag
// Build option:
//   SLEW_LIMIT_EN   when defined, limits each committed increase to MAX_STEP
// ============================================================================
module motor_update_scheduler #(
  parameter int TIMEOUT_CYCLES = 320000,
  parameter int ARM_FRAMES     = 16,
  parameter int MAX_STEP       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  speed_valid,
  input  logic [63:0] speedFlat,
  output logic        upd_valid,
  output logic [2:0]  upd_motor,
  output logic [7:0]  upd_speed,
  input  logic        upd_ready,
  output logic [63:0] targetSpeedFlat,
  output logic [7:0]  armed,
  output logic [7:0]  timeout_flags
);

  localparam logic [0:0]  ST_IDLE      = 1'b0;
  localparam logic [0:0]  ST_OFFER     = 1'b1;
  localparam logic [19:0] c_TIMER_LOAD = 20'(TIMEOUT_CYCLES);
  localparam logic [7:0]  c_ARM_FRAMES = 8'(ARM_FRAMES);

  // Parameter sanity: reject configurations the counters cannot represent.
  if (ARM_FRAMES < 1 || ARM_FRAMES > 255 || MAX_STEP < 0 || MAX_STEP > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575) begin : g_bad_param
    $error("motor_update_scheduler: parameter out of range");
  end

  logic [0:0] r_state;
  logic [2:0] r_ptr;
  logic       r_upd_valid;
  logic [2:0] r_upd_motor;
  logic [7:0] r_upd_speed;

  logic [7:0] w_pending;
  logic [7:0] w_armed;
  logic [7:0] w_tflag;
  logic [7:0] w_cap    [8];
  logic [7:0] w_target [8];
  logic [7:0] w_grant_clr;
  logic [7:0] w_commit;

  logic       w_found;
  logic [2:0] w_sel;
  logic [2:0] w_idx;
  logic [7:0] w_sel_cap;
  logic [7:0] w_grant_speed;
  logic       w_keep_pending;

  // --------------------------------------------------------------------------
  // Round-robin search: walk from ptr+7 down to ptr so the last hit, which is
  // the closest set bit at or above ptr (with wrap), ends up selected.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found = |w_pending;
    w_sel   = r_ptr;
    w_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      w_idx = r_ptr + 3'(i);
      if (w_pending[w_idx]) begin
        w_sel = w_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Grant value. With the slew limiter, the comparison is done in 9 bits so
  // committed + MAX_STEP cannot wrap; a limited grant keeps the pending bit so
  // the motor ramps over later grants.
  // --------------------------------------------------------------------------
`ifdef SLEW_LIMIT_EN
  localparam logic [8:0] c_MAX_STEP9 = 9'(MAX_STEP);
  logic [8:0] w_limit;

  always_comb begin
    w_sel_cap = w_cap[w_sel];
    w_limit   = {1'b0, w_target[w_sel]} + c_MAX_STEP9;
    if ({1'b0, w_sel_cap} > w_limit) begin
      w_grant_speed  = w_limit[7:0];
      w_keep_pending = 1'b1;
    end else begin
      w_grant_speed  = w_sel_cap;
      w_keep_pending = 1'b0;
    end
  end
`else
  always_comb begin
    w_sel_cap      = w_cap[w_sel];
    w_grant_speed  = w_sel_cap;
    w_keep_pending = 1'b0;
  end
`endif

  // --------------------------------------------------------------------------
  // Arbiter FSM. The offer is frozen until the handshake; the pointer moves
  // past the granted motor only once the update is accepted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 3'd0;
      r_upd_valid <= 1'b0;
      r_upd_motor <= 3'd0;
      r_upd_speed <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_upd_valid <= 1'b1;
            r_upd_motor <= w_sel;
            r_upd_speed <= w_grant_speed;
            r_state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (upd_ready) begin
            r_upd_valid <= 1'b0;
            r_ptr       <= r_upd_motor + 3'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_upd_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-motor capture, arming, watchdog and committed speed.
  // --------------------------------------------------------------------------
  for (genvar m = 0; m < 8; m++) begin : g_motor
    logic [7:0]  w_speed;
    logic [7:0]  r_cap;
    logic [7:0]  r_target;
    logic [7:0]  r_arm_cnt;
    logic [19:0] r_timer;
    logic        r_pending;
    logic        r_armed;
    logic        r_tflag;

    assign w_speed        = speedFlat[8*(7-m) +: 8];
    assign w_grant_clr[m] = (r_state == ST_IDLE) && w_found &&
                            (w_sel == 3'(m)) && !w_keep_pending;
    assign w_commit[m]    = (r_state == ST_OFFER) && upd_ready &&
                            (r_upd_motor == 3'(m));

    // A strobe outranks both expiry and a same-cycle grant, so the most
    // recent frame is never dropped.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cap     <= 8'd0;
        r_arm_cnt <= 8'd0;
        r_timer   <= 20'd0;
        r_pending <= 1'b0;
        r_armed   <= 1'b0;
        r_tflag   <= 1'b1;
      end else if (speed_valid[m]) begin
        r_timer   <= c_TIMER_LOAD;
        r_tflag   <= 1'b0;
        r_pending <= 1'b1;
        if (r_armed) begin
          r_cap <= w_speed;
        end else begin
          r_cap <= 8'd0;
          if (w_speed != 8'd0) begin
            r_arm_cnt <= 8'd0;
          end else if (r_arm_cnt != c_ARM_FRAMES) begin
            r_arm_cnt <= r_arm_cnt + 8'd1;
          end
          if (r_arm_cnt == c_ARM_FRAMES) begin
            r_armed <= 1'b1;
          end
        end
      end else if (r_timer == 20'd1) begin
        // Signal lost: disarm and force a zero-speed update.
        r_timer   <= 20'd0;
        r_tflag   <= 1'b1;
        r_armed   <= 1'b0;
        r_arm_cnt <= 8'd0;
        r_cap     <= 8'd0;
        r_pending <= 1'b1;
      end else begin
        if (r_timer != 20'd0) begin
          r_timer <= r_timer - 20'd1;
        end
        if (!r_armed && (r_arm_cnt == c_ARM_FRAMES)) begin
          r_armed <= 1'b1;
        end
        if (w_grant_clr[m]) begin
          r_pending <= 1'b0;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_target <= 8'd0;
      end else if (w_commit[m]) begin
        r_target <= r_upd_speed;
      end
    end

    assign w_pending[m]                = r_pending;
    assign w_armed[m]                  = r_armed;
    assign w_tflag[m]                  = r_tflag;
    assign w_cap[m]                    = r_cap;
    assign w_target[m]                 = r_target;
    assign targetSpeedFlat[8*(7-m) +: 8] = r_target;
  end

  assign upd_valid     = r_upd_valid;
  assign upd_motor     = r_upd_motor;
  assign upd_speed     = r_upd_speed;
  assign armed         = w_armed;
  assign timeout_flags = w_tflag;

endmodule
`default_nettype wire

// File: tb/tb_motor_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_update_scheduler
// Purpose  : Directed, self-checking bench for motor_update_scheduler:
//            reset state, arming, capture, round-robin order, watchdog,
//            offer stability and (with SLEW_LIMIT_EN) the ramp limiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_motor_update_scheduler;

  localparam int TO = 400;

  logic        clk;
  logic        rst;
  logic [7:0]  speed_valid;
  logic [63:0] speedFlat;
  logic        upd_ready;
  logic        upd_valid;
  logic [2:0]  upd_motor;
  logic [7:0]  upd_speed;
  logic [63:0] targetSpeedFlat;
  logic [7:0]  armed;
  logic [7:0]  timeout_flags;

  int n_checks = 0;
  int n_errors = 0;
  int got[$];
  logic stable;

  typedef struct {
    int         motor;
    logic [7:0] speed;
    logic [7:0] exp_speed;
  } vec_t;
  vec_t vecs[8];

  motor_update_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .ARM_FRAMES    (16),
    .MAX_STEP      (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .speed_valid    (speed_valid),
    .speedFlat      (speedFlat),
    .upd_valid      (upd_valid),
    .upd_motor      (upd_motor),
    .upd_speed      (upd_speed),
    .upd_ready      (upd_ready),
    .targetSpeedFlat(targetSpeedFlat),
    .armed          (armed),
    .timeout_flags  (timeout_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] slice(input logic [63:0] v, input int m);
    return v[8*(7-m) +: 8];
  endfunction

  task automatic do_reset();
    rst = 1'b1; speed_valid = '0; speedFlat = '0; upd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic strobe(input int m, input logic [7:0] s);
    speed_valid = 8'(1 << m);
    speedFlat[8*(7-m) +: 8] = s;
    tick();
    speed_valid = '0;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n = 0;
    while (!upd_valid && n < max_cycles) begin
      tick();
      n++;
    end
    if (!upd_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no upd_valid expected offer within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic take(input string name, input int m, input logic [7:0] s);
    wait_valid(name, 10);
    check({name, " motor"}, 64'(upd_motor), 64'(m));
    check({name, " speed"}, 64'(upd_speed), 64'(s));
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    check({name, " target"}, 64'(slice(targetSpeedFlat, m)), 64'(s));
  endtask

  // Sends 16 zero frames with the consumer always ready, then drains.
  task automatic arm_motor(input int m);
    upd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      strobe(m, 8'd0);
      tick(); tick();
    end
    repeat (4) tick();
    upd_ready = 1'b0;
  endtask

  // Records the motor (sel_speed=0) or speed (sel_speed=1) of every offer.
  task automatic record(input int n, input bit sel_speed);
    for (int k = 0; k < n; k++) begin
      if (upd_valid) got.push_back(sel_speed ? int'(upd_speed) : int'(upd_motor));
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{0, 8'd100, 8'd100};
    vecs[1] = '{0, 8'd0,   8'd0};
    vecs[2] = '{0, 8'd255, 8'd255};
    vecs[3] = '{5, 8'd1,   8'd1};
    vecs[4] = '{5, 8'd128, 8'd128};
    vecs[5] = '{2, 8'd50,  8'd0};
    vecs[6] = '{7, 8'd0,   8'd0};
    vecs[7] = '{0, 8'd1,   8'd1};

    // Reset state
    do_reset();
    check("rst upd_valid", 64'(upd_valid), 64'd0);
    check("rst upd_motor", 64'(upd_motor), 64'd0);
    check("rst upd_speed", 64'(upd_speed), 64'd0);
    check("rst target",    targetSpeedFlat, 64'd0);
    check("rst armed",     64'(armed), 64'd0);
    check("rst tflags",    64'(timeout_flags), 64'hFF);

    // Simultaneous strobes on motors 2,5,8 -> indices 1,4,7 in order
    upd_ready = 1'b1;
    speed_valid = 8'b1001_0010;
    tick();
    speed_valid = '0;
    got.delete();
    record(20, 1'b0);
    check("rr count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) check("rr order", 64'(i < got.size() ? got[i] : 99), 64'(1 + 3*i));
    // Pointer wrapped to 0: motor index 0 must beat index 7
    speed_valid = 8'b1000_0001;
    tick();
    speed_valid = '0;
    got.delete();
    record(12, 1'b0);
    check("rr wrap count", 64'(got.size()), 64'd2);
    check("rr wrap first", 64'(got.size() > 0 ? got[0] : 99), 64'd0);
    upd_ready = 1'b0;

`ifndef SLEW_LIMIT_EN
    // Arming on motor 1, then first real speed
    do_reset();
    upd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      strobe(0, 8'd0);
      if (k == 14) check("t1 armed after 15", 64'(armed[0]), 64'd0);
      if (k == 15) begin
        tick();
        check("t1 armed after 16", 64'(armed[0]), 64'd1);
      end
      tick(); tick();
    end
    repeat (4) tick();
    upd_ready = 1'b0;
    strobe(0, 8'd100);
    take("t1", 0, 8'd100);
    check("t1 tflag", 64'(timeout_flags[0]), 64'd0);

    // Unarmed motor 3 with nonzero speed commits 0 and restarts arm count
    strobe(2, 8'd50);
    take("t2", 2, 8'd0);
    check("t2 armed", 64'(armed[2]), 64'd0);
    upd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin strobe(2, 8'd0); tick(); tick(); end
    strobe(2, 8'd50); tick(); tick();
    for (int k = 0; k < 15; k++) begin strobe(2, 8'd0); tick(); tick(); end
    check("t2 restart not armed", 64'(armed[2]), 64'd0);
    strobe(2, 8'd0);
    tick();
    check("t2 restart armed", 64'(armed[2]), 64'd1);
    repeat (4) tick();
    upd_ready = 1'b0;

    // Watchdog: expiry exactly TO cycles after the last strobe
    do_reset();
    arm_motor(0);
    upd_ready = 1'b1;
    strobe(0, 8'd100);
    repeat (TO - 1) tick();
    check("t4 flag before", 64'(timeout_flags[0]), 64'd0);
    check("t4 armed before", 64'(armed[0]), 64'd1);
    check("t4 target before", 64'(slice(targetSpeedFlat, 0)), 64'd100);
    upd_ready = 1'b0;
    tick();
    check("t4 flag", 64'(timeout_flags[0]), 64'd1);
    check("t4 armed", 64'(armed[0]), 64'd0);
    take("t4", 0, 8'd0);

    // Offer stays frozen while the same motor strobes twice; latest wins
    arm_motor(0);
    strobe(0, 8'd70);
    wait_valid("t5 first", 10);
    check("t5 first speed", 64'(upd_speed), 64'd70);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin speed_valid = 8'd1; speedFlat[63:56] = 8'd80; end
      else if (k == 5) begin speed_valid = 8'd1; speedFlat[63:56] = 8'd90; end
      else speed_valid = '0;
      tick();
      if (!(upd_valid && upd_motor == 3'd0 && upd_speed == 8'd70)) stable = 1'b0;
    end
    speed_valid = '0;
    check("t5 stable", 64'(stable), 64'd1);
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    check("t5 first target", 64'(slice(targetSpeedFlat, 0)), 64'd70);
    take("t5 second", 0, 8'd90);
    repeat (4) tick();
    check("t5 single update", 64'(upd_valid), 64'd0);

    // Table of single-update vectors
    do_reset();
    arm_motor(0);
    arm_motor(5);
    for (int i = 0; i < 8; i++) begin
      strobe(vecs[i].motor, vecs[i].speed);
      take($sformatf("vec%0d", i), vecs[i].motor, vecs[i].exp_speed);
    end
`else
    // Slew limiter: 0 -> 10 ramps 4, 8, 10; a drop passes straight through
    do_reset();
    arm_motor(0);
    upd_ready = 1'b1;
    strobe(0, 8'd10);
    got.delete();
    record(20, 1'b1);
    check("slew count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      check("slew step", 64'(i < got.size() ? got[i] : 999), (i == 2) ? 64'd10 : 64'(4*(i+1)));
    check("slew target", 64'(slice(targetSpeedFlat, 0)), 64'd10);
    strobe(0, 8'd2);
    got.delete();
    record(10, 1'b1);
    check("slew drop count", 64'(got.size()), 64'd1);
    check("slew drop value", 64'(got.size() > 0 ? got[0] : 999), 64'd2);
    check("slew drop target", 64'(slice(targetSpeedFlat, 0)), 64'd2);
    upd_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
